// File: rtl/if_src_ctrl.sv
// IF-stage source select: stalls the PC and injects NOPs ahead of a BNE whose operands are still in flight, then replays it; flushes on taken branch.
// Outputs are combinational (same-cycle NOP on hazard); replay follows 1 or 2 NOP cycles; branch_taken overrides everything.
module if_src_ctrl #(
  parameter logic [5:0]  BNE_OPCODE   = 6'b000101,
  parameter logic [31:0] NOP_WORD     = 32'h0000_0000,
  parameter int          FLUSH_CYCLES = 2,
  parameter int          CNT_W        = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_valid,
  input  logic [31:0] if_instr,
  input  logic        idex_regwrite,
  input  logic [4:0]  idex_rd,
  input  logic        exmem_regwrite,
  input  logic [4:0]  exmem_rd,
  input  logic        branch_taken,
  output logic [1:0]  IRSrcIF,
  output logic [31:0] bne_word,
  output logic [31:0] nop_word,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STALL  = 2'd1,
    S_REPLAY = 2'd2,
    S_FLUSH  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_bne_hold;

  state_t           w_next_state;
  logic [CNT_W-1:0] w_next_cnt;
  logic             w_capture;
  logic [4:0]       w_rs;
  logic [4:0]       w_rt;
  logic             w_is_bne;
  logic             w_idex_match;
  logic             w_exmem_match;
  logic             w_haz;

  assign w_rs     = if_instr[25:21];
  assign w_rt     = if_instr[20:16];
  assign w_is_bne = if_valid && (if_instr[31:26] == BNE_OPCODE);

  // r0 is hardwired, so a write to it never creates a dependency
  assign w_idex_match  = idex_regwrite && (idex_rd != 5'd0) &&
                         ((w_rs == idex_rd) || (w_rt == idex_rd));
  assign w_exmem_match = exmem_regwrite && (exmem_rd != 5'd0) &&
                         ((w_rs == exmem_rd) || (w_rt == exmem_rd));
  assign w_haz         = w_is_bne && (w_idex_match || w_exmem_match);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_bne_hold <= 32'h0000_0000;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      if (w_capture) begin
        r_bne_hold <= if_instr;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_capture    = 1'b0;
    if (branch_taken) begin
      w_next_cnt   = FLUSH_LOAD;
      w_next_state = (FLUSH_CYCLES == 1) ? S_IDLE : S_FLUSH;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_haz) begin
            w_capture    = 1'b1;
            w_next_cnt   = w_idex_match ? CNT_W'(1) : '0;
            w_next_state = w_idex_match ? S_STALL : S_REPLAY;
          end
        end
        // the count reaching zero on this edge ends the phase
        S_STALL: begin
          if (r_cnt <= CNT_W'(1)) begin
            w_next_cnt   = '0;
            w_next_state = S_REPLAY;
          end else begin
            w_next_cnt = r_cnt - CNT_W'(1);
          end
        end
        S_REPLAY: begin
          w_next_state = S_IDLE;
        end
        S_FLUSH: begin
          if (r_cnt <= CNT_W'(1)) begin
            w_next_cnt   = '0;
            w_next_state = S_IDLE;
          end else begin
            w_next_cnt = r_cnt - CNT_W'(1);
          end
        end
        default: begin
          w_next_cnt   = '0;
          w_next_state = S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    IRSrcIF     = 2'b00;
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    if (!rst_n) begin
      IRSrcIF     = 2'b01;
      pc_write    = 1'b0;
      if_id_write = 1'b0;
    end else if (branch_taken) begin
      IRSrcIF = 2'b01;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_haz) begin
            IRSrcIF  = 2'b01;
            pc_write = 1'b0;
          end
        end
        S_STALL: begin
          IRSrcIF  = 2'b01;
          pc_write = 1'b0;
        end
        S_REPLAY: IRSrcIF = 2'b10;
        S_FLUSH:  IRSrcIF = 2'b01;
        default:  IRSrcIF = 2'b01;
      endcase
    end
  end

  assign bne_word = rst_n ? r_bne_hold : 32'h0000_0000;
  assign nop_word = NOP_WORD;
  assign busy     = rst_n && (r_state != S_IDLE);

endmodule

// File: tb/tb_if_src_ctrl.sv
// Directed bench for if_src_ctrl: reset forcing, stall/replay lengths, r0 and non-BNE filtering, flush priority and restart.
module tb_if_src_ctrl;

  logic        clk;
  logic        rst_n;
  logic        if_valid;
  logic [31:0] if_instr;
  logic        idex_regwrite;
  logic [4:0]  idex_rd;
  logic        exmem_regwrite;
  logic [4:0]  exmem_rd;
  logic        branch_taken;
  logic [1:0]  IRSrcIF;
  logic [31:0] bne_word;
  logic [31:0] nop_word;
  logic        pc_write;
  logic        if_id_write;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  if_src_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .idex_regwrite  (idex_regwrite),
    .idex_rd        (idex_rd),
    .exmem_regwrite (exmem_regwrite),
    .exmem_rd       (exmem_rd),
    .branch_taken   (branch_taken),
    .IRSrcIF        (IRSrcIF),
    .bne_word       (bne_word),
    .nop_word       (nop_word),
    .pc_write       (pc_write),
    .if_id_write    (if_id_write),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mk_instr(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt);
    mk_instr = {op, rs, rt, 16'h1234};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [1:0] src, input logic pcw,
                         input logic ifw, input logic bsy);
    check({tag, ".src"},  32'(IRSrcIF),     32'(src));
    check({tag, ".pcw"},  32'(pc_write),    32'(pcw));
    check({tag, ".ifw"},  32'(if_id_write), 32'(ifw));
    check({tag, ".busy"}, 32'(busy),        32'(bsy));
  endtask

  // advance to just after the next rising edge, then clear all stimulus
  task automatic next_cycle();
    @(posedge clk);
    #2;
    if_valid       = 1'b0;
    if_instr       = 32'h0;
    idex_regwrite  = 1'b0;
    idex_rd        = 5'd0;
    exmem_regwrite = 1'b0;
    exmem_rd       = 5'd0;
    branch_taken   = 1'b0;
  endtask

  logic [31:0] instr_a;
  logic [31:0] instr_b;
  logic [31:0] instr_c;

  initial begin
    rst_n = 1'b0;
    if_valid = 1'b0; if_instr = 32'h0; idex_regwrite = 1'b0; idex_rd = 5'd0;
    exmem_regwrite = 1'b0; exmem_rd = 5'd0; branch_taken = 1'b0;

    for (int i = 0; i < 3; i++) begin
      next_cycle(); #1;
      chk_out("reset", 2'b01, 1'b0, 1'b0, 1'b0);
      check("reset.bne_word", bne_word, 32'h0);
    end
    check("nop_word", nop_word, 32'h0000_0000);
    rst_n = 1'b1;
    next_cycle(); #1;
    chk_out("post_reset", 2'b00, 1'b1, 1'b1, 1'b0);

    // ID/EX dependency on rs: two NOPs then replay
    instr_a = mk_instr(6'b000101, 5'd5, 5'd3);
    next_cycle();
    if_valid = 1'b1; if_instr = instr_a; idex_regwrite = 1'b1; idex_rd = 5'd5; #1;
    chk_out("idex.t0", 2'b01, 1'b0, 1'b1, 1'b0);
    next_cycle(); #1;
    chk_out("idex.t1", 2'b01, 1'b0, 1'b1, 1'b1);
    check("idex.t1.word", bne_word, instr_a);
    next_cycle(); #1;
    chk_out("idex.t2", 2'b10, 1'b1, 1'b1, 1'b1);
    check("idex.t2.word", bne_word, instr_a);
    next_cycle(); #1;
    chk_out("idex.t3", 2'b00, 1'b1, 1'b1, 1'b0);

    // EX/MEM-only dependency on rt: one NOP then replay
    instr_b = mk_instr(6'b000101, 5'd2, 5'd7);
    next_cycle();
    if_valid = 1'b1; if_instr = instr_b; exmem_regwrite = 1'b1; exmem_rd = 5'd7;
    idex_regwrite = 1'b1; idex_rd = 5'd9; #1;
    chk_out("exmem.t0", 2'b01, 1'b0, 1'b1, 1'b0);
    next_cycle(); #1;
    chk_out("exmem.t1", 2'b10, 1'b1, 1'b1, 1'b1);
    check("exmem.t1.word", bne_word, instr_b);
    next_cycle(); #1;
    chk_out("exmem.t2", 2'b00, 1'b1, 1'b1, 1'b0);

    // r0 never matches
    next_cycle();
    if_valid = 1'b1; if_instr = mk_instr(6'b000101, 5'd0, 5'd4);
    idex_regwrite = 1'b1; idex_rd = 5'd0; #1;
    chk_out("r0", 2'b00, 1'b1, 1'b1, 1'b0);
    // invalid fetch never stalls
    next_cycle();
    if_valid = 1'b0; if_instr = mk_instr(6'b000101, 5'd6, 5'd1);
    idex_regwrite = 1'b1; idex_rd = 5'd6; #1;
    chk_out("invalid", 2'b00, 1'b1, 1'b1, 1'b0);
    // non-BNE opcode with a matching source does not stall
    next_cycle();
    if_valid = 1'b1; if_instr = mk_instr(6'b000100, 5'd6, 5'd1);
    idex_regwrite = 1'b1; idex_rd = 5'd6; #1;
    chk_out("not_bne", 2'b00, 1'b1, 1'b1, 1'b0);
    // matching register but regwrite low
    next_cycle();
    if_valid = 1'b1; if_instr = mk_instr(6'b000101, 5'd6, 5'd1);
    exmem_rd = 5'd1; idex_rd = 5'd6; #1;
    chk_out("no_regwrite", 2'b00, 1'b1, 1'b1, 1'b0);
    check("no_regwrite.word", bne_word, instr_b);

    // branch taken while stalled discards the replay
    instr_c = mk_instr(6'b000101, 5'd8, 5'd1);
    next_cycle();
    if_valid = 1'b1; if_instr = instr_c; idex_regwrite = 1'b1; idex_rd = 5'd8; #1;
    chk_out("stflush.t0", 2'b01, 1'b0, 1'b1, 1'b0);
    next_cycle();
    branch_taken = 1'b1; #1;
    chk_out("stflush.t1", 2'b01, 1'b1, 1'b1, 1'b1);
    next_cycle(); #1;
    chk_out("stflush.t2", 2'b01, 1'b1, 1'b1, 1'b1);
    next_cycle(); #1;
    chk_out("stflush.t3", 2'b00, 1'b1, 1'b1, 1'b0);
    next_cycle(); #1;
    chk_out("stflush.t4", 2'b00, 1'b1, 1'b1, 1'b0);
    check("stflush.word", bne_word, instr_c);

    // hazard and flush together: flush wins, then a second flush restarts the count
    next_cycle();
    if_valid = 1'b1; if_instr = mk_instr(6'b000101, 5'd6, 5'd6);
    idex_regwrite = 1'b1; idex_rd = 5'd6; branch_taken = 1'b1; #1;
    chk_out("haz_bt.t0", 2'b01, 1'b1, 1'b1, 1'b0);
    next_cycle();
    branch_taken = 1'b1; #1;
    chk_out("haz_bt.t1", 2'b01, 1'b1, 1'b1, 1'b1);
    next_cycle(); #1;
    chk_out("haz_bt.t2", 2'b01, 1'b1, 1'b1, 1'b1);
    check("haz_bt.word", bne_word, instr_c);
    next_cycle(); #1;
    chk_out("haz_bt.t3", 2'b00, 1'b1, 1'b1, 1'b0);
    check("haz_bt.t3.word", bne_word, instr_c);

    // reset mid-STALL drops the held BNE
    next_cycle();
    if_valid = 1'b1; if_instr = instr_a; idex_regwrite = 1'b1; idex_rd = 5'd3; #1;
    chk_out("rst_stall.t0", 2'b01, 1'b0, 1'b1, 1'b0);
    next_cycle(); #1;
    chk_out("rst_stall.t1", 2'b01, 1'b0, 1'b1, 1'b1);
    rst_n = 1'b0; #1;
    chk_out("rst_stall.in", 2'b01, 1'b0, 1'b0, 1'b0);
    check("rst_stall.word", bne_word, 32'h0);
    next_cycle();
    rst_n = 1'b1; #1;
    chk_out("rst_stall.rel", 2'b00, 1'b1, 1'b1, 1'b0);
    next_cycle(); #1;
    chk_out("rst_stall.after", 2'b00, 1'b1, 1'b1, 1'b0);
    check("rst_stall.after.word", bne_word, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/if_src_ctrl.md
# if_src_ctrl

IF-stage instruction-source controller: drives the 2-bit `IRSrcIF` select of the IF→ID instruction mux, plus the NOP and BNE words that mux chooses between. It detects a BNE in IF whose source registers are still being produced by instructions in ID/EX or EX/MEM. On such a hazard it captures the BNE, stalls the PC, injects NOPs, then replays the captured BNE. It also flushes the IF slot with NOPs when a taken branch resolves.

## Interface
- `BNE_OPCODE`, 6'b000101, opcode value in `if_instr[31:26]` identifying BNE
- `NOP_WORD`, 32'h0000_0000, word driven on `nop_word`
- `FLUSH_CYCLES`, 2, NOP cycles injected per taken-branch flush (≥1)
- `CNT_W`, 2, width of internal down-counter (must hold max(2, FLUSH_CYCLES)−1)

Ports:
- `clk`  in  1  clock, all state on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `if_valid`  in  1  `if_instr` holds a real fetched instruction
- `if_instr`  in  32  instruction currently in IF; rs=[25:21], rt=[20:16]
- `idex_regwrite`  in  1  instruction in ID/EX writes a register
- `idex_rd`  in  5  its destination
- `exmem_regwrite`  in  1  instruction in EX/MEM writes a register
- `exmem_rd`  in  5  its destination
- `branch_taken`  in  1  taken branch resolved this cycle (flush request)
- `IRSrcIF`  out  2  00 pass IF_ID, 01 NOP, 10 replayed BNE
- `bne_word`  out  32  captured BNE instruction (hold register)
- `nop_word`  out  32  constant `NOP_WORD`
- `pc_write`  out  1  PC update enable
- `if_id_write`  out  1  IF/ID register write enable
- `busy`  out  1  state ≠ IDLE

## Operation
- States: IDLE, STALL, REPLAY, FLUSH. 2-bit state reg, `CNT_W` counter `cnt`, 32-bit `bne_hold`.
- Hazard (`haz`) = `if_valid` & opcode==`BNE_OPCODE` & (src match), where src match = rs or rt equals a nonzero rd with its regwrite high. Register 0 never matches.
- Stall length `len` = 2 if any ID/EX match, else 1 (EX/MEM-only match).
- Outputs are combinational from state and inputs (Mealy in IDLE):
  - IDLE, no `haz`, no `branch_taken`: `IRSrcIF`=00, `pc_write`=1, `if_id_write`=1.
  - IDLE + `haz`: `IRSrcIF`=01, `pc_write`=0, `if_id_write`=1; capture `if_instr` into `bne_hold`; `cnt`←`len`−1; next STALL if `len`=2, else REPLAY.
  - STALL: `IRSrcIF`=01, `pc_write`=0; `cnt` decrements; when `cnt`=0 at the edge → REPLAY.
  - REPLAY: `IRSrcIF`=10, `pc_write`=1, `if_id_write`=1; next IDLE. No hazard re-check.
  - FLUSH: `IRSrcIF`=01, `pc_write`=1, `if_id_write`=1; `cnt` decrements; when `cnt`=0 → IDLE.
- `branch_taken` has priority in every state. That cycle: `IRSrcIF`=01, `pc_write`=1. `cnt`←`FLUSH_CYCLES`−1, and any pending replay is discarded. Next state is FLUSH, or IDLE if `FLUSH_CYCLES`=1. `branch_taken` during FLUSH restarts the count.
- `bne_word` = `bne_hold` at all times; `bne_hold` is written only on hazard capture.

## Timing
- Reset (async assert, sync release on next edge): state=IDLE, `cnt`=0, `bne_hold`=0.
- While `rst_n`=0, outputs are forced: `IRSrcIF`=01, `pc_write`=0, `if_id_write`=0, `bne_word`=0, `busy`=0.
- Hazard detect to NOP output: 0 cycles (same cycle).
- Total NOP cycles before replay = `len`; the replay appears in cycle t+`len`.
- Flush NOPs: exactly `FLUSH_CYCLES` consecutive cycles starting the `branch_taken` cycle.
- Simultaneous `haz` and `branch_taken` in IDLE: flush wins, `bne_hold` is not written.
- `if_valid`=0: never a hazard.
- Reset mid-STALL or mid-FLUSH: the held BNE is dropped, and the block returns to IDLE after release.

## Test plan
- Reset held 3 cycles then released, no hazards → during reset `IRSrcIF`=01, `pc_write`=0; after release `IRSrcIF`=00, `pc_write`=1, `busy`=0.
- BNE rs=5 in IF, `idex_rd`=5 with `idex_regwrite`=1 → `IRSrcIF`=01,01,10,00 over t..t+3; `pc_write`=0,0,1,1; `bne_word`=captured instr from t+0.
- BNE rt=7, `exmem_rd`=7 with `exmem_regwrite`=1, no ID/EX match → `IRSrcIF`=01,10,00.
- BNE rs=0, `idex_rd`=0 with `idex_regwrite`=1 → no stall, `IRSrcIF`=00.
- Enter STALL, then `branch_taken` at t+1 → `IRSrcIF`=01 for t+1,t+2 then 00; 10 never emitted; `pc_write`=1 from t+1.
- `haz` and `branch_taken` same cycle, then `branch_taken` again in FLUSH → count restarts: `IRSrcIF`=01 for FLUSH_CYCLES cycles after the second request; `bne_word` unchanged from its prior value.
